// File: rtl/ab_pattern_gen.sv
// Symbol-pattern generator for the two-input (a,b) detector interface.
// Loads up to DEPTH 2-bit {a,b} symbols, then plays them one per clock, optionally repeated.
module ab_pattern_gen #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int REP_W = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_data,
    input  logic             clear,
    input  logic             start,
    input  logic [REP_W-1:0] repeat_cnt,
    output logic             a,
    output logic             b,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [PTR_W:0]   level,
    output logic             full,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE
    } state_t;

    localparam logic [PTR_W:0] LEVEL_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] IDX_ONE   = (PTR_W+1)'(1);

    state_t             state_q, state_d;
    logic [PTR_W:0]     level_q, level_d;
    logic [PTR_W:0]     idx_q, idx_d;
    logic [REP_W-1:0]   pass_q, pass_d;
    logic [1:0]         ab_q, ab_d;
    logic               err_q, err_d;
    logic               mem_we;
    logic [1:0]         first_sym;
    logic [1:0]         sym_mem_q [DEPTH];

    logic full_w;
    assign full_w = (level_q == LEVEL_MAX);

    // NOTE: the symbol store has no reset; its contents are qualified by level_q,
    // so clearing it would only cost a reset net on every storage bit.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            sym_mem_q[level_q[PTR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            ab_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            ab_q    <= ab_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        ab_d      = ab_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        first_sym = sym_mem_q[0];

        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    level_d = '0;
                end else if (wr_en) begin
                    if (full_w) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        level_d = level_q + 1'b1;
                    end
                end
                // A write into an empty buffer must be playable on the same edge.
                if (level_q == '0 && mem_we) begin
                    first_sym = wr_data;
                end
                if (start) begin
                    if (level_d == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PLAY;
                        ab_d    = first_sym;
                        idx_d   = IDX_ONE;
                        pass_d  = repeat_cnt;
                    end
                end
            end

            ST_PLAY: begin
                if (wr_en || clear || start) begin
                    err_d = 1'b1;
                end
                if (idx_q < level_q) begin
                    ab_d  = sym_mem_q[idx_q[PTR_W-1:0]];
                    idx_d = idx_q + 1'b1;
                end else if (pass_q != '0) begin
                    pass_d = pass_q - 1'b1;
                    ab_d   = sym_mem_q[0];
                    idx_d  = IDX_ONE;
                end else begin
                    ab_d    = '0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a     = ab_q[1];
        b     = ab_q[0];
        valid = (state_q == ST_PLAY);
        busy  = (state_q == ST_PLAY);
        done  = (state_q == ST_DONE);
        level = level_q;
        full  = full_w;
        err   = err_q;
    end

endmodule

// File: tb/tb_ab_pattern_gen.sv
// Scoreboard bench for ab_pattern_gen: a queue-based model predicts every played
// symbol and done pulse; a negedge monitor pops and compares whatever the DUT presents.
module tb_ab_pattern_gen;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int REP_W = 4;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             wr_en;
    logic [1:0]       wr_data;
    logic             clear;
    logic             start;
    logic [REP_W-1:0] repeat_cnt;
    logic             a, b, valid, busy, done, full, err;
    logic [PTR_W:0]   level;

    ab_pattern_gen #(.DEPTH(DEPTH), .PTR_W(PTR_W), .REP_W(REP_W)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clear      (clear),
        .start      (start),
        .repeat_cnt (repeat_cnt),
        .a          (a),
        .b          (b),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .level      (level),
        .full       (full),
        .err        (err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       is_done;
        logic [1:0] sym;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] mq[$];
    logic       m_err;
    logic       in_burst;
    int         n_checks;
    int         n_err;

    task automatic flag_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every valid or done cycle consumes one expected entry.
    always @(negedge Clk) begin
        if (Rst === 1'b0) begin
            if (valid || done) begin
                if (exp_q.size() == 0) begin
                    flag_fail("unexpected_output");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_done) begin
                        check("done_pulse", {29'd0, done, valid, busy}, 32'b100);
                        in_burst = 1'b0;
                    end else begin
                        check("symbol", {28'd0, valid, busy, a, b}, {28'd0, 2'b11, e.sym});
                        in_burst = 1'b1;
                    end
                end
            end else begin
                check("idle_ab_zero", {30'd0, a, b}, 32'd0);
                if (in_burst) begin
                    flag_fail("gap_in_playback");
                    in_burst = 1'b0;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        mq.delete();
        exp_q.delete();
        m_err    = 1'b0;
        in_burst = 1'b0;
        cycle();
        Rst = 1'b0;
        cycle();
    endtask

    task automatic model_write(input logic [1:0] s);
        if (mq.size() < DEPTH) mq.push_back(s);
        else m_err = 1'b1;
    endtask

    task automatic model_start(input int rep);
        exp_t e;
        for (int p = 0; p <= rep; p++) begin
            foreach (mq[k]) begin
                e.is_done = 1'b0;
                e.sym     = mq[k];
                exp_q.push_back(e);
            end
        end
        e.is_done = 1'b1;
        e.sym     = 2'b00;
        exp_q.push_back(e);
    endtask

    task automatic do_write(input logic [1:0] s);
        wr_en   = 1'b1;
        wr_data = s;
        model_write(s);
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        mq.delete();
        cycle();
        clear = 1'b0;
    endtask

    task automatic do_start(input int rep);
        start      = 1'b1;
        repeat_cnt = REP_W'(rep);
        model_start(rep);
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0 && !busy && !done) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        if (!ok) flag_fail("timeout_waiting_idle");
    endtask

    task automatic check_status(input string tag);
        check({tag, "_level"}, 32'(level), 32'(mq.size()));
        check({tag, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
        check({tag, "_err"}, 32'(err), 32'(m_err));
    endtask

    initial begin
        Rst = 1'b1; wr_en = 1'b0; wr_data = 2'b00; clear = 1'b0; start = 1'b0; repeat_cnt = '0;
        n_checks = 0; n_err = 0; m_err = 1'b0; in_burst = 1'b0;
        #12;
        check("reset_outputs", {25'd0, a, b, valid, busy, done, full, err}, 32'd0);
        check("reset_level", 32'(level), 32'd0);
        Rst = 1'b0;
        cycle();

        // Directed: 01,11,11,00 once, then three passes.
        do_write(2'b01); do_write(2'b11); do_write(2'b11); do_write(2'b00);
        check_status("load4");
        do_start(0);
        wait_idle();
        do_start(2);
        wait_idle();
        check_status("replay");

        // Inputs during PLAY are ignored apart from err.
        do_start(0);
        wr_en = 1'b1; wr_data = 2'b10; clear = 1'b1;
        m_err = 1'b1;
        cycle();
        wr_en = 1'b0; clear = 1'b0;
        wait_idle();
        check_status("play_ignore");

        // Start on an empty buffer: done only, err stays clear.
        do_reset();
        do_start(0);
        wait_idle();
        check_status("empty_start");

        // Write and start on the same edge into an empty buffer.
        wr_en = 1'b1; wr_data = 2'b10; start = 1'b1; repeat_cnt = 1;
        model_write(2'b10);
        model_start(1);
        cycle();
        wr_en = 1'b0; start = 1'b0;
        wait_idle();
        check_status("wr_start");

        // Overflow: nine writes into eight slots.
        do_clear();
        for (int i = 0; i < 9; i++) do_write(2'($urandom_range(0, 3)));
        check_status("overflow");
        do_start(0);
        wait_idle();

        // Single symbol at maximum repeat count.
        do_reset();
        do_write(2'b11);
        do_start((1 << REP_W) - 1);
        wait_idle();
        check_status("lvl1_maxrep");

        // Randomized loads and repeat counts.
        for (int it = 0; it < 8; it++) begin
            int n;
            do_clear();
            n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) do_write(2'($urandom_range(0, 3)));
            do_start(int'($urandom_range(0, 3)));
            wait_idle();
            check_status("random");
        end

        // Asynchronous reset on the third symbol of a four-symbol playback.
        do_clear();
        do_write(2'b01); do_write(2'b11); do_write(2'b10); do_write(2'b00);
        do_start(0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20 && seen < 3; i++) begin
                @(negedge Clk);
                if (valid) seen++;
            end
            if (seen < 3) flag_fail("third_symbol_not_seen");
        end
        #2;
        Rst = 1'b1;
        #1;
        check("async_reset_outputs", {28'd0, a, b, valid, busy}, 32'd0);
        exp_q.delete();
        mq.delete();
        m_err    = 1'b0;
        in_burst = 1'b0;
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("no_done_after_reset", 32'(done), 32'd0);
        end
        check_status("after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ab_pattern_gen.md
Name: ab_pattern_gen

Overview:
- Transmit end of the two-input (a,b) sequence-detector interface.
- Software/bench loads a short list of 2-bit {a,b} symbols, then plays it onto the a/b lines one symbol per clock, optionally repeated.
- The output drives a detector's a/b inputs directly, so detector sequences are produced in hardware instead of by hand-timed bench stimulus.

Parameters:
- DEPTH, 8, symbol buffer capacity (power of 2, 2..16).
- PTR_W, 3, log2(DEPTH).
- REP_W, 4, width of the repeat-count input.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write one symbol into the buffer this cycle.
- wr_data  input  2  symbol; bit1 = a, bit0 = b.
- clear  input  1  empty the buffer (IDLE only).
- start  input  1  begin playback (IDLE only).
- repeat_cnt  input  REP_W  extra passes; 0 = play once.
- a  output  1  played symbol bit a (registered).
- b  output  1  played symbol bit b (registered).
- valid  output  1  a/b carry a played symbol this cycle.
- busy  output  1  high in PLAY.
- done  output  1  one-cycle pulse after the last symbol.
- level  output  PTR_W+1  number of loaded symbols, 0..DEPTH.
- full  output  1  level == DEPTH.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, Rst=1): state=IDLE; a=b=valid=busy=done=err=0; level=0; buffer contents don't-care. Rst mid-PLAY aborts immediately with no done pulse.
- States: IDLE, PLAY, DONE.
- IDLE, writes:
  - wr_en and not full: buf[level] <= wr_data, level+1.
  - wr_en and full: write dropped, err <= 1.
- IDLE, clear: level <= 0. clear has priority over wr_en in the same cycle.
- IDLE, start with level > 0: pass <= repeat_cnt, idx <= 1.
  - The same edge drives a/b <= buf[0], and sets valid=1, busy=1, state=PLAY.
  - Latency: first symbol is visible on the edge that samples start.
- IDLE, start with level == 0: go to DONE directly (done pulse, no valid cycles).
- IDLE, start together with wr_en/clear: the write/clear applies first; start is evaluated against the new level.
- PLAY, each edge:
  - If idx < level: a/b <= buf[idx], idx+1.
  - Else if pass > 0: pass-1, a/b <= buf[0], idx <= 1. Wrap is seamless; valid stays high.
  - Else: a=b=valid=busy=0, state=DONE.
- PLAY, ignored inputs: wr_en, clear and start have no effect except setting err <= 1. Buffer and level are unchanged.
- Total valid cycles = level*(repeat_cnt+1), contiguous.
- DONE: done=1 for exactly one cycle, then IDLE. The buffer is retained, so start replays the same pattern.
- err clears only on Rst.
- level == 1 wraps every cycle; repeat_cnt at max (2^REP_W-1) gives 2^REP_W passes with no overflow.
- Outputs a/b are 0 whenever valid=0.

Test Plan:
- Reset then load 01,11,11,00 (4 writes); start with repeat_cnt=0 -> level=4; valid high for exactly 4 cycles; {a,b}=01,11,11,00; done pulses 1 cycle later; busy falls with valid.
- Same buffer, start with repeat_cnt=2 -> 12 contiguous valid cycles, pattern repeated 3 times with no gap at the wraps; a single done pulse.
- Write 9 symbols with DEPTH=8 -> level=8, full=1, err=1; the 9th symbol is never played.
- start with level=0 -> no valid cycle; done=1 on the cycle after the start edge; err stays 0.
- During PLAY, assert wr_en with 10 and clear -> err=1; playback continues unchanged; level unchanged afterwards.
- Assert Rst on the 3rd symbol of a 4-symbol playback -> a=b=valid=busy=0 immediately (asynchronous, before the next edge); no done; level=0.
